// File: rtl/shifter_pkg.sv
// shifter_pkg: shared definitions for the iterative shift/rotate unit.
//   - op encoding constants (OP_ROL, OP_SLL, OP_ROR, OP_SRL)
//   - FSM state type and state constants (StIdle, StShift, StDone)
//   - SHAMT_W: width of the shift amount
//   - bits_above(): mask of shamt bits strictly above a given stage index
package shifter_pkg;

  localparam int unsigned SHAMT_W = 4;

  typedef logic [1:0] op_t;
  localparam op_t OP_ROL = 2'b00;
  localparam op_t OP_SLL = 2'b01;
  localparam op_t OP_ROR = 2'b10;
  localparam op_t OP_SRL = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StShift = 2'd1;
  localparam state_t StDone  = 2'd2;

  // Mask selecting shamt bits above stage idx; all-zero for the last stage.
  function automatic logic [SHAMT_W-1:0] bits_above(input logic [1:0] idx);
    logic [SHAMT_W-1:0] m;
    m = '1;
    m = m << ({1'b0, idx} + 3'd1);
    return m;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one combinational log2 stage of the iterative shifter.
// Shifts or rotates by the fixed distance DIST when enabled, else passes data through.
// Ports:
//   op   in  2      operation (ROL, SLL, ROR, SRL)
//   en   in  1      apply this stage's distance
//   din  in  WIDTH  data in
//   dout out WIDTH  data out
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIST  = 1
) (
  input  logic [1:0]       op,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) begin
      unique case (op)
        OP_ROL: dout = {din[WIDTH-1-DIST:0], din[WIDTH-1:WIDTH-DIST]};
        OP_SLL: dout = {din[WIDTH-1-DIST:0], {DIST{1'b0}}};
        OP_ROR: dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
        OP_SRL: dout = {{DIST{1'b0}}, din[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/shifter_seq.sv
// shifter_seq: iterative 16-bit shift/rotate unit, one log2 stage (1, 2, 4, 8) per clock.
// A start accepted in IDLE or DONE loads the operand into the result register; four
// SHIFT cycles follow, then a one-cycle done pulse. The result holds until the next start.
// Build option: define SHIFTER_EARLY_EXIT_EN to leave SHIFT once no higher shamt bit is set.
// Ports:
//   clk    in  1      clock, rising edge
//   rst    in  1      synchronous active-high reset
//   start  in  1      request, honoured only in IDLE or DONE
//   op     in  2      00 ROL, 01 SLL, 10 ROR, 11 SRL
//   in     in  WIDTH  operand
//   shamt  in  4      amount 0..15
//   busy   out 1      high while shifting
//   done   out 1      one-cycle completion pulse
//   out    out WIDTH  result register
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic [WIDTH-1:0]   stage_out [4];
  logic               last_stage;

  for (genvar g = 0; g < 4; g++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << g)
    ) u_stage (
      .op   (op_q),
      .en   (shamt_q[g]),
      .din  (out_q),
      .dout (stage_out[g])
    );
  end

`ifdef SHIFTER_EARLY_EXIT_EN
  // Remaining stages would all be pass-through, so finish now.
  assign last_stage = (cnt_q == 2'd3) || ((shamt_q & bits_above(cnt_q)) == '0);
`else
  assign last_stage = (cnt_q == 2'd3);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    out_d   = out_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          out_d   = in;
          op_d    = op;
          shamt_d = shamt;
          cnt_d   = 2'd0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        out_d = stage_out[cnt_q];
        if (last_stage) begin
          cnt_d   = 2'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      op_q    <= 2'd0;
      shamt_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign out  = out_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq: behavioural reference model plus directed cases
// with literal expectations and a randomized run.
module tb_shifter_seq;
  import shifter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] din = 16'h0000;
  logic [3:0]  shamt = 4'h0;
  logic        busy, done;
  logic [15:0] dout;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Reference model state: cycles of busy remaining, done flag, visible result.
  int          m_wait = 0;
  bit          m_done = 1'b0;
  logic [15:0] m_out = 16'h0000;
  logic [15:0] m_result = 16'h0000;

  shifter_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .in    (din),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .out   (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] x,
                                             input logic [3:0] s);
    logic [31:0] w;
    w = {x, x};
    case (o)
      2'b00: begin w = w << s; return w[31:16]; end
      2'b10: begin w = w >> s; return w[15:0]; end
      2'b01: return x << s;
      default: return x >> s;
    endcase
  endfunction

  // Number of cycles busy stays high for a given amount.
  function automatic int busy_cycles(input logic [3:0] s);
`ifdef SHIFTER_EARLY_EXIT_EN
    for (int i = 3; i >= 1; i--) if (s[i]) return i + 1;
    return 1;
`else
    return (s == s) ? 4 : 4;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_wait <= 0;
      m_done <= 1'b0;
      m_out  <= 16'h0000;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      m_done <= (m_wait == 1);
      if (m_wait == 1) m_out <= m_result;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_out    <= din;
        m_result <= ref_result(op, din, shamt);
        m_wait   <= busy_cycles(shamt);
      end
    end
  end

  // Compare process: every cycle; the result is only meaningful outside SHIFT.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {15'd0, busy}, {15'd0, m_wait > 0});
      check("done", {15'd0, done}, {15'd0, m_done});
      if (m_wait == 0) check("out", dout, m_out);
      if (done) n_done++;
    end
  end

  // Called at a negedge; drives start for one cycle and waits (bounded) for done.
  task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] x,
                        input logic [3:0] s, input logic [15:0] exp_lit, input int exp_lat,
                        input bit poke);
    int c0;
    bit seen;
    start = 1'b1; op = o; din = x; shamt = s;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (poke && busy) begin
        start = 1'b1; op = ~o; din = ~x; shamt = s ^ 4'h5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 20 cycles", name);
    end else begin
      check({name, "_lat"}, 16'(cyc - c0), 16'(exp_lat));
      check({name, "_out"}, dout, exp_lit);
    end
  endtask

  initial begin
    int d0;
`ifdef SHIFTER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    // Pin the reference model itself.
    check("model_rol", ref_result(2'b00, 16'h8001, 4'd1), 16'h0003);
    check("model_ror", ref_result(2'b10, 16'h1234, 4'd4), 16'h4123);
    check("model_srl", ref_result(2'b11, 16'hF000, 4'd15), 16'h0001);
    check("model_sll", ref_result(2'b01, 16'hFFFF, 4'd8), 16'hFF00);

    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_out", dout, 16'h0000);
    check("idle_busy", {15'd0, busy}, 16'd0);

    run_op("rol", OP_ROL, 16'h8001, 4'd1, 16'h0003, EE ? 2 : 5, 1'b0);
    repeat (2) @(negedge clk);
    run_op("ror", OP_ROR, 16'h1234, 4'd4, 16'h4123, EE ? 4 : 5, 1'b0);
    repeat (3) @(negedge clk);
    run_op("srl", OP_SRL, 16'hF000, 4'd15, 16'h0001, 5, 1'b0);
    @(negedge clk);
    run_op("sll", OP_SLL, 16'hFFFF, 4'd8, 16'hFF00, 5, 1'b0);
    // Back-to-back: issued in the DONE cycle of the previous operation.
    run_op("b2b", OP_ROL, 16'h00FF, 4'd0, 16'h00FF, EE ? 2 : 5, 1'b0);
    repeat (4) @(negedge clk);
    check("idle_hold", dout, 16'h00FF);

    // Starts while busy must be ignored.
    d0 = n_done;
    run_op("poke", OP_SLL, 16'h0F0F, 4'd3, 16'h7878, EE ? 3 : 5, 1'b1);
    repeat (8) @(negedge clk);
    check("poke_dones", 16'(n_done - d0), 16'd1);

    // Reset in cycle N+3 of an operation.
    start = 1'b1; op = OP_SRL; din = 16'hFFFF; shamt = 4'd15;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_out", dout, 16'h0000);
    d0 = n_done;
    repeat (8) @(negedge clk);
    check("rst_no_done", 16'(n_done - d0), 16'd0);

    // Randomized traffic, including starts while busy and rst with start.
    d0 = n_done;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom);
      din   = 16'($urandom);
      shamt = 4'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("rand_activity", {15'd0, (n_done - d0) > 100}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
